// File: rtl/prbs_lfsr_xor.sv
// prbs_lfsr_xor: parametrised Fibonacci LFSR pseudo-random bit source.
//
// The generator advances one step per enabled cycle using XOR feedback over
// the bits selected by TAPS. A load port reseeds the register directly. The
// all-zero state (reachable only through a load of zero) is a lock-up state
// for XOR feedback, so it is detected and replaced by SEED on the next cycle,
// with a one-cycle lockup pulse.
//
// Optional feature, enabled by defining the macro PRBS_LFSR_CHECK_EN:
// a self-synchronising checker that runs a received bit stream through its
// own shift register, predicts each bit from the previous WIDTH bits and
// counts mismatches in a saturating error counter. With the macro undefined
// the checker and its ports are absent; the generator is identical.

module prbs_lfsr_xor #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'hC,
    parameter logic [WIDTH-1:0] SEED  = 4'h1,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             out_bit,
    output logic             lockup
`ifdef PRBS_LFSR_CHECK_EN
    ,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             err_clr,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    // A register shorter than 3 bits, an empty counter or an all-zero seed
    // cannot produce a useful sequence, so such builds are refused outright.
    generate
        if (WIDTH < 3 || CNT_W < 1 || SEED == '0) begin : g_param_check
            $error("prbs_lfsr_xor: WIDTH must be >= 3, CNT_W >= 1 and SEED non-zero");
        end
    endgenerate

    // One Fibonacci step: shift left, feedback bit enters at the bottom.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    logic [WIDTH-1:0] state_nxt;
    logic             lockup_nxt;

    // Next-state choice: load, then lock-up recovery, then step, else hold.
    always_comb begin
        state_nxt  = state;
        lockup_nxt = 1'b0;
        if (load) begin
            state_nxt = seed_in;
        end else if (state == '0) begin
            // en is deliberately ignored here: zero would step to zero forever.
            state_nxt  = SEED;
            lockup_nxt = 1'b1;
        end else if (en) begin
            state_nxt = lfsr_step(state);
        end
    end

    // Generator register; reset restores the seed and drops the lock-up flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SEED;
            lockup <= 1'b0;
        end else begin
            state  <= state_nxt;
            lockup <= lockup_nxt;
        end
    end

    assign out_bit = state[WIDTH-1];

`ifdef PRBS_LFSR_CHECK_EN
    // sync_cnt must be able to hold the value WIDTH itself.
    localparam int unsigned     SYNC_W    = $clog2(WIDTH + 1);
    localparam logic [SYNC_W-1:0] SYNC_FULL = SYNC_W'(WIDTH);

    // Error count stops at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0]  chk;
    logic [SYNC_W-1:0] sync_cnt;
    logic              pred;
    logic              synced;
    logic              mismatch;

    // The receiver regenerates the expected bit from the last WIDTH received
    // bits, so it locks to the stream without any knowledge of the sender.
    assign pred     = ^(chk & TAPS);
    assign synced   = (sync_cnt == SYNC_FULL);
    assign mismatch = rx_valid && synced && (rx_bit != pred);

    // Receive shift register: follows valid bits, emptied by a clear.
    // Its contents are ignored until sync_cnt fills, so rst need not touch it.
    always_ff @(posedge clk) begin
        if (err_clr) begin
            chk <= '0;
        end else if (rx_valid) begin
            chk <= {chk[WIDTH-2:0], rx_bit};
        end
    end

    // Sync counter, registered error pulse and saturating error count.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            sync_cnt <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err <= mismatch;
            if (rx_valid && !synced) begin
                sync_cnt <= sync_cnt + SYNC_W'(1);
            end
            if (err) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_lfsr_xor.sv
// Directed bench for prbs_lfsr_xor with default parameters.
// Generator vectors are a table of {inputs, expected state/lockup}; the
// optional checker (PRBS_LFSR_CHECK_EN) is exercised by hand-written streams.

module tb_prbs_lfsr_xor;

    localparam int CNT_W = 16;

    // Output bit stream for one period starting from state 1 (bit i = pat[i]):
    // 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1
    localparam logic [14:0] PAT = 15'b111101011001000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] seed_in;
    logic [3:0] state;
    logic       out_bit;
    logic       lockup;
`ifdef PRBS_LFSR_CHECK_EN
    logic             rx_bit;
    logic             rx_valid;
    logic             err_clr;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    prbs_lfsr_xor #(
        .WIDTH (4),
        .TAPS  (4'hC),
        .SEED  (4'h1),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .seed_in (seed_in),
        .state   (state),
        .out_bit (out_bit),
        .lockup  (lockup)
`ifdef PRBS_LFSR_CHECK_EN
        ,
        .rx_bit  (rx_bit),
        .rx_valid(rx_valid),
        .err_clr (err_clr),
        .err     (err),
        .err_cnt (err_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [3:0] seed;
        logic [3:0] st;
        logic       lk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic l,
                       input logic [3:0] s, input logic [3:0] st, input logic lk);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.seed = s; v.st = st; v.lk = lk;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat_bit(input int i);
        logic [14:0] t;
        t = PAT >> (i % 15);
        return t[0];
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 4'h0;
`ifdef PRBS_LFSR_CHECK_EN
        rx_bit = 1'b0; rx_valid = 1'b0; err_clr = 1'b0;
`endif

        //   rst  en   load seed   state lockup
        // reset, 2 cycles (second with en high: reset wins)
        add(1, 0, 0, 4'h0, 4'h1, 0);
        add(1, 1, 0, 4'h0, 4'h1, 0);
        // full period
        add(0, 1, 0, 4'h0, 4'h2, 0);
        add(0, 1, 0, 4'h0, 4'h4, 0);
        add(0, 1, 0, 4'h0, 4'h9, 0);
        add(0, 1, 0, 4'h0, 4'h3, 0);
        add(0, 1, 0, 4'h0, 4'h6, 0);
        add(0, 1, 0, 4'h0, 4'hD, 0);
        add(0, 1, 0, 4'h0, 4'hA, 0);
        add(0, 1, 0, 4'h0, 4'h5, 0);
        add(0, 1, 0, 4'h0, 4'hB, 0);
        add(0, 1, 0, 4'h0, 4'h7, 0);
        add(0, 1, 0, 4'h0, 4'hF, 0);
        add(0, 1, 0, 4'h0, 4'hE, 0);
        add(0, 1, 0, 4'h0, 4'hC, 0);
        add(0, 1, 0, 4'h0, 4'h8, 0);
        add(0, 1, 0, 4'h0, 4'h1, 0);
        // run to A, then hold for 5 cycles
        add(0, 1, 0, 4'h0, 4'h2, 0);
        add(0, 1, 0, 4'h0, 4'h4, 0);
        add(0, 1, 0, 4'h0, 4'h9, 0);
        add(0, 1, 0, 4'h0, 4'h3, 0);
        add(0, 1, 0, 4'h0, 4'h6, 0);
        add(0, 1, 0, 4'h0, 4'hD, 0);
        add(0, 1, 0, 4'h0, 4'hA, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 4'h3, 4'hA, 0);
        // load beats en, then stepping resumes from the loaded value
        add(0, 1, 1, 4'h7, 4'h7, 0);
        add(0, 1, 0, 4'h0, 4'hF, 0);
        // load of zero, reseed with lockup pulse, resume
        add(0, 1, 1, 4'h0, 4'h0, 0);
        add(0, 1, 0, 4'h0, 4'h1, 1);
        add(0, 1, 0, 4'h0, 4'h2, 0);
        add(0, 1, 0, 4'h0, 4'h4, 0);
        // reseed also happens with en low; afterwards en low holds
        add(0, 0, 1, 4'h0, 4'h0, 0);
        add(0, 0, 0, 4'h0, 4'h1, 1);
        add(0, 0, 0, 4'h0, 4'h1, 0);
        // load beats reseed when the state is zero
        add(0, 0, 1, 4'h0, 4'h0, 0);
        add(0, 0, 1, 4'h5, 4'h5, 0);
        add(0, 1, 0, 4'h0, 4'hB, 0);
        // reset beats reseed: no lockup pulse
        add(0, 0, 1, 4'h0, 4'h0, 0);
        add(1, 1, 0, 4'h0, 4'h1, 0);
        // reset at state D with en high: no step taken
        add(0, 0, 1, 4'hD, 4'hD, 0);
        add(1, 1, 0, 4'h0, 4'h1, 0);
        add(0, 1, 0, 4'h0, 4'h2, 0);
        // reset beats load
        add(1, 1, 1, 4'h9, 4'h1, 0);
        add(0, 1, 1, 4'hC, 4'hC, 0);
        add(0, 1, 0, 4'h0, 4'h8, 0);
        add(0, 1, 0, 4'h0, 4'h1, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; load = vecs[i].load; seed_in = vecs[i].seed;
            tick();
            check("state", i, 32'(state), 32'(vecs[i].st));
            check("out_bit", i, 32'(out_bit), 32'(vecs[i].st[3]));
            check("lockup", i, 32'(lockup), 32'(vecs[i].lk));
`ifdef PRBS_LFSR_CHECK_EN
            if (vecs[i].rst) begin
                check("rst_err", i, 32'(err), 32'd0);
                check("rst_err_cnt", i, 32'(err_cnt), 32'd0);
            end
`endif
        end
        rst = 1'b0; en = 1'b0; load = 1'b0;

`ifdef PRBS_LFSR_CHECK_EN
        begin
            int k;
            int nerr;
            int hits[$];
            int h0, h1, h2;

            // Clear with a valid but wrong bit present: the clear wins.
            err_clr = 1'b1; rx_valid = 1'b1; rx_bit = 1'b1;
            tick();
            check("clr_err", 0, 32'(err), 32'd0);
            check("clr_err_cnt", 0, 32'(err_cnt), 32'd0);
            err_clr = 1'b0;

            // Clean loopback stream with gaps carrying garbage bits.
            k = 0; nerr = 0;
            for (int c = 0; c < 100; c++) begin
                if (c % 7 == 6) begin
                    rx_valid = 1'b0; rx_bit = ~pat_bit(k);
                end else begin
                    rx_valid = 1'b1; rx_bit = pat_bit(k); k++;
                end
                tick();
                if (err) nerr++;
            end
            rx_valid = 1'b0;
            tick();
            check("loop_err_pulses", 0, nerr, 0);
            check("loop_err_cnt", 0, 32'(err_cnt), 32'd0);

            // One inverted bit after sync: pulses at +0, +3, +4 valid bits.
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            for (int i = 0; i < 40; i++) begin
                rx_valid = 1'b1;
                rx_bit = pat_bit(i) ^ (i == 20);
                tick();
                if (err) hits.push_back(i);
            end
            rx_valid = 1'b0;
            tick();
            tick();
            h0 = (hits.size() > 0) ? hits[0] : -1;
            h1 = (hits.size() > 1) ? hits[1] : -1;
            h2 = (hits.size() > 2) ? hits[2] : -1;
            check("inv_pulse_count", 0, hits.size(), 3);
            check("inv_pulse_pos", 0, h0, 20);
            check("inv_pulse_pos", 1, h1, 23);
            check("inv_pulse_pos", 2, h2, 24);
            check("inv_err_cnt", 0, 32'(err_cnt), 32'd3);

            // Clear, then restart mid-sequence: no errors while resyncing.
            err_clr = 1'b1; rx_valid = 1'b1; rx_bit = 1'b1;
            tick();
            check("clr2_err_cnt", 0, 32'(err_cnt), 32'd0);
            check("clr2_err", 0, 32'(err), 32'd0);
            err_clr = 1'b0;
            nerr = 0;
            for (int i = 0; i < 20; i++) begin
                rx_valid = 1'b1;
                rx_bit = pat_bit(i + 3);
                tick();
                if (err) nerr++;
            end
            rx_valid = 1'b0;
            tick();
            check("resync_err_pulses", 0, nerr, 0);
            check("resync_err_cnt", 0, 32'(err_cnt), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
